gps_sync_controller: RTL and testbench
======================================

// Module: gps_sync_controller
// PURPOSE
//  Arbitrates the seconds source for clock_counter between GPS 1PPS and the ms_counter backup tick.
//  Qualifies each PPS edge against a +/-tolerance window and sequences acquisition, lock, holdover and free-run.
//  Issues a load strobe so parsed GPS time is loaded in phase with PPS.
//  Sits between GPS_Clock_Data/ms_counter and clock_counter/misc_pwm.
// PARAMETERS
//  CLK_HZ      50000000  clk cycles per nominal second
//  PPS_TOL     50000     accepted PPS interval deviation, cycles (+/-)
//  LOCK_COUNT  3         consecutive good PPS intervals required to lock
//  HOLDOVER_S  600       backup seconds tolerated in HOLDOVER before FREERUN
// PORTS
//  clk         in   1  system clock, 50 MHz
//  reset       in   1  synchronous, active-high
//  pps_in      in   1  single-cycle PPS pulse (pps_single_clk)
//  backup_sec  in   1  single-cycle backup second tick from ms_counter
//  time_valid  in   1  single-cycle pulse: parser latched a new BCD time
//  sec_tick    out  1  selected single-cycle seconds increment to clock_counter
//  load_time   out  1  single-cycle strobe: clock_counter loads GPS time
//  sync_state  out  2  0 ACQUIRE, 1 LOCKED, 2 HOLDOVER, 3 FREERUN
//  gps_lock    out  1  high only in LOCKED
//  holdover    out  1  high only in HOLDOVER
// BEHAVIOUR
//  Reset values: sec_tick=0, load_time=0, sync_state=ACQUIRE, gps_lock=0, holdover=0.
//  Reset values (internal): good_cnt=0, ivl=saturated, ho_cnt=0, time_fresh=0.
//  All outputs are registered. Latency is 1 cycle from the qualifying input pulse to sec_tick/load_time.
//  Interval counter ivl:
//   - Restarts at 0 on every pps_in; otherwise increments.
//   - Saturates at 2*CLK_HZ. Width is $clog2(2*CLK_HZ+1).
//  PPS classification:
//   - good: LO<=ivl<=HI, where LO=CLK_HZ-PPS_TOL and HI=CLK_HZ+PPS_TOL.
//   - early: ivl<LO.
//   - A saturated ivl counts as not good.
//   - The first PPS after reset only starts a measurement.
//  time_fresh:
//   - Set by time_valid; cleared on any pps_in.
//   - If time_valid and pps_in occur in the same cycle, the set wins: the time belongs to the next second.
//  ACQUIRE:
//   - sec_tick = backup_sec.
//   - good PPS: good_cnt++. Any other PPS: good_cnt=0.
//   - good PPS with good_cnt==LOCK_COUNT-1 and time_fresh: go to LOCKED and pulse load_time; good_cnt=0.
//   - good PPS reaching the count with time_fresh=0: hold good_cnt at LOCK_COUNT-1 and stay.
//  LOCKED:
//   - sec_tick = pps_in; backup_sec is ignored, so a coincident backup_sec never double-ticks.
//   - good PPS with time_fresh: pulse load_time together with sec_tick.
//   - early PPS: go to ACQUIRE; good_cnt=0; no tick.
//   - ivl reaches HI+1 with no PPS: go to HOLDOVER; ho_cnt=0.
//  HOLDOVER:
//   - sec_tick = backup_sec; each backup_sec increments ho_cnt.
//   - ho_cnt reaches HOLDOVER_S: go to FREERUN.
//   - any PPS: go to ACQUIRE; good_cnt=0; the interval measurement restarts.
//  FREERUN:
//   - sec_tick = backup_sec.
//   - any PPS: go to ACQUIRE.
//  load_time is never asserted outside a PPS cycle.
//  Reset asserted mid-operation overrides everything in that cycle.
// STRUCTURE
//  Shared package gps_clock_pkg: sync_state encodings (ST_ACQUIRE..ST_FREERUN) and the default CLK_HZ constant.
//  Sub-module pps_interval_checker: ivl counter, window compare, timeout flag.
//   - Outputs pps_good, pps_early, pps_timeout.
//  This module: FSM, good_cnt, ho_cnt, time_fresh, output mux/registers.
// TESTING (CLK_HZ=1000, PPS_TOL=10, LOCK_COUNT=3, HOLDOVER_S=5)
//  PPS every 1000 cycles, time_valid 300 cycles after each PPS:
//   -> LOCKED 1 cycle after the 4th PPS, with load_time=1 and sec_tick=1 in that cycle.
//  Lock, then stop PPS:
//   -> HOLDOVER at ivl=1011.
//   -> sec_tick follows backup_sec.
//   -> FREERUN after the 5th backup_sec.
//  Lock, then a PPS at ivl=500:
//   -> ACQUIRE, no sec_tick, gps_lock=0.
//   -> Relock needs 3 further good intervals.
//  Good PPS without time_valid:
//   -> stays ACQUIRE.
//   -> The first PPS after a time_valid locks with load_time.
//  LOCKED with backup_sec and pps_in in the same cycle:
//   -> exactly one sec_tick.
//  time_valid coincident with pps_in: time_fresh=1 afterwards.
//  Reset pulse while LOCKED: all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/gps_clock_pkg.sv
// Shared GPS clock types: sync state encodings
// and the nominal system clock rate.
package gps_clock_pkg;

  localparam int CLK_HZ_DEF = 50_000_000;

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2,
    ST_FREERUN  = 2'd3
  } sync_state_t;

endpackage

// File: rtl/pps_interval_checker.sv
// Measures cycles between PPS pulses and
// classifies each pulse against the tolerance window.
module pps_interval_checker
  import gps_clock_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int PPS_TOL = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pps_in,
  output logic pps_good,
  output logic pps_early,
  output logic pps_timeout
);

  localparam int W = $clog2(2 * CLK_HZ + 1);
  localparam logic [W-1:0] SAT = W'(2 * CLK_HZ);
  localparam logic [W-1:0] LO  = W'(CLK_HZ - PPS_TOL);
  localparam logic [W-1:0] HI  = W'(CLK_HZ + PPS_TOL);

  logic [W-1:0] ivl;

  always_ff @(posedge clk) begin
    if (reset) begin
      ivl <= SAT;
    end else if (pps_in) begin
      ivl <= '0;
    end else if (ivl != SAT) begin
      ivl <= ivl + 1'b1;
    end
  end

  // A saturated count means no valid reference edge yet
  assign pps_good = pps_in && (ivl != SAT)
                 && (ivl >= LO) && (ivl <= HI);
  assign pps_early   = pps_in && (ivl < LO);
  assign pps_timeout = (ivl > HI);

endmodule

// File: rtl/gps_sync_controller.sv
// Selects GPS PPS or backup tick as the seconds source
// and sequences acquire/lock/holdover/free-run.
module gps_sync_controller
  import gps_clock_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int PPS_TOL    = 50000,
  parameter int LOCK_COUNT = 3,
  parameter int HOLDOVER_S = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pps_in,
  input  logic       backup_sec,
  input  logic       time_valid,
  output logic       sec_tick,
  output logic       load_time,
  output logic [1:0] sync_state,
  output logic       gps_lock,
  output logic       holdover
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int HW = $clog2(HOLDOVER_S + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [HW-1:0] HO_LAST   = HW'(HOLDOVER_S - 1);

  sync_state_t   state;
  logic [GW-1:0] good_cnt;
  logic [HW-1:0] ho_cnt;
  logic          time_fresh;
  logic          pps_good;
  logic          pps_early;
  logic          pps_timeout;

  pps_interval_checker #(
    .CLK_HZ  (CLK_HZ),
    .PPS_TOL (PPS_TOL)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .pps_in      (pps_in),
    .pps_good    (pps_good),
    .pps_early   (pps_early),
    .pps_timeout (pps_timeout)
  );

  assign sync_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ACQUIRE;
      sec_tick   <= 1'b0;
      load_time  <= 1'b0;
      gps_lock   <= 1'b0;
      holdover   <= 1'b0;
      good_cnt   <= '0;
      ho_cnt     <= '0;
      time_fresh <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      load_time <= 1'b0;
      // A time arriving with PPS belongs to the next second
      if (time_valid) begin
        time_fresh <= 1'b1;
      end else if (pps_in) begin
        time_fresh <= 1'b0;
      end
      unique case (state)
        ST_ACQUIRE: begin
          sec_tick <= backup_sec;
          if (pps_good && good_cnt == GOOD_LAST) begin
            if (time_fresh) begin
              state     <= ST_LOCKED;
              gps_lock  <= 1'b1;
              sec_tick  <= 1'b1;
              load_time <= 1'b1;
              good_cnt  <= '0;
            end
          end else if (pps_good) begin
            good_cnt <= good_cnt + 1'b1;
          end else if (pps_in) begin
            good_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (pps_good) begin
            sec_tick  <= 1'b1;
            load_time <= time_fresh;
          end else if (pps_in) begin
            state    <= ST_ACQUIRE;
            gps_lock <= 1'b0;
            good_cnt <= '0;
          end else if (pps_timeout) begin
            state    <= ST_HOLDOVER;
            gps_lock <= 1'b0;
            holdover <= 1'b1;
            ho_cnt   <= '0;
          end
        end
        ST_HOLDOVER: begin
          sec_tick <= backup_sec;
          if (pps_in) begin
            state    <= ST_ACQUIRE;
            holdover <= 1'b0;
            good_cnt <= '0;
          end else if (backup_sec) begin
            ho_cnt <= ho_cnt + 1'b1;
            if (ho_cnt == HO_LAST) begin
              state    <= ST_FREERUN;
              holdover <= 1'b0;
            end
          end
        end
        ST_FREERUN: begin
          sec_tick <= backup_sec;
          if (pps_in) begin
            state    <= ST_ACQUIRE;
            good_cnt <= '0;
          end
        end
        default: begin
          state <= ST_ACQUIRE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_sync_controller.sv
// Scoreboard bench for gps_sync_controller with
// directed PPS / backup / time_valid sequences.
module tb_gps_sync_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pps_in = 1'b0;
  logic       backup_sec = 1'b0;
  logic       time_valid = 1'b0;
  logic       sec_tick;
  logic       load_time;
  logic [1:0] sync_state;
  logic       gps_lock;
  logic       holdover;

  localparam logic [1:0] ACQ = 2'd0;
  localparam logic [1:0] LCK = 2'd1;
  localparam logic [1:0] HOL = 2'd2;
  localparam logic [1:0] FRE = 2'd3;

  gps_sync_controller #(
    .CLK_HZ     (1000),
    .PPS_TOL    (10),
    .LOCK_COUNT (3),
    .HOLDOVER_S (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pps_in     (pps_in),
    .backup_sec (backup_sec),
    .time_valid (time_valid),
    .sec_tick   (sec_tick),
    .load_time  (load_time),
    .sync_state (sync_state),
    .gps_lock   (gps_lock),
    .holdover   (holdover)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit t;
    bit l;
  } tick_rec_t;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    bit         lk;
    bit         ho;
    bit         t;
    bit         l;
    string      nm;
  } st_rec_t;

  tick_rec_t tq[$];
  st_rec_t   sq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  bit fin      = 1'b0;

  // Monitor: pops expectations when the DUT shows output
  always @(negedge clk) begin
    tick_rec_t e;
    st_rec_t   s;
    while (tq.size() > 0 && tq[0].cyc < cyc) begin
      e = tq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_tick: expected at cycle %0d, no tick observed", e.cyc);
    end
    if (sec_tick || load_time) begin
      n_checks++;
      if (tq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: cycle %0d tick=%0b load=%0b, required none",
                 cyc, sec_tick, load_time);
      end else begin
        e = tq.pop_front();
        if (e.cyc != cyc || e.t != sec_tick || e.l != load_time) begin
          n_fail++;
          $display("FAIL tick: cycle %0d tick=%0b load=%0b, required cycle %0d tick=%0b load=%0b",
                   cyc, sec_tick, load_time, e.cyc, e.t, e.l);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      n_checks++;
      if (s.cyc != cyc || s.st != sync_state || s.lk != gps_lock ||
          s.ho != holdover || s.t != sec_tick || s.l != load_time) begin
        n_fail++;
        $display("FAIL %s: st=%0d lock=%0b ho=%0b tick=%0b load=%0b, required st=%0d lock=%0b ho=%0b tick=%0b load=%0b",
                 s.nm, sync_state, gps_lock, holdover, sec_tick, load_time,
                 s.st, s.lk, s.ho, s.t, s.l);
      end
    end
    if (done && !fin) begin
      n_checks++;
      if (tq.size() != 0 || sq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: %0d ticks %0d states pending, required 0 0",
                 tq.size(), sq.size());
      end
      fin = 1'b1;
    end
  end

  // One clock cycle of stimulus; et/el is the response one cycle later
  task automatic drive(input bit p, input bit b, input bit t,
                       input bit et, input bit el);
    if (et || el) tq.push_back('{cyc + 1, et, el});
    pps_in     = p;
    backup_sec = b;
    time_valid = t;
    @(posedge clk);
    #1;
    pps_in     = 1'b0;
    backup_sec = 1'b0;
    time_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_st(input string nm, input logic [1:0] st,
                           input bit lk, input bit ho,
                           input bit t, input bit l);
    sq.push_back('{cyc, st, lk, ho, t, l, nm});
  endtask

  // PPS after 'gap' cycles; optional time_valid / backup inside the gap
  task automatic second(input int gap, input bit tv, input bit bk,
                        input bit bk_t, input bit et, input bit el);
    for (int i = 1; i < gap; i++)
      drive(1'b0, bk && i == 500, tv && i == 300,
            bk && bk_t && i == 500, 1'b0);
    drive(1'b1, 1'b0, 1'b0, et, el);
  endtask

  initial begin
    @(posedge clk);
    #1;
    idle(3);
    expect_st("reset_state", ACQ, 0, 0, 0, 0);
    reset = 1'b0;
    idle(2);

    // Acquire: first PPS only starts the measurement
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    second(1000, 1, 0, 0, 0, 0);
    expect_st("acq_pps2", ACQ, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 0, 0);
    expect_st("acq_pps3", ACQ, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 1, 1);
    expect_st("lock_pps4", LCK, 1, 0, 1, 1);

    // Locked: backup ignored, coincident backup gives one tick
    second(1000, 1, 1, 0, 1, 1);
    expect_st("locked_load", LCK, 1, 0, 1, 1);
    second(1000, 0, 0, 0, 1, 0);
    expect_st("locked_noload", LCK, 1, 0, 1, 0);
    idle(999);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_st("pps_bk_same", LCK, 1, 0, 1, 0);

    // Loss of PPS: holdover at ivl 1011, then free-run
    idle(1011);
    expect_st("pre_timeout", LCK, 1, 0, 0, 0);
    idle(1);
    expect_st("holdover", HOL, 0, 1, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      idle(99);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (j == 4) expect_st("ho_4th", HOL, 0, 1, 1, 0);
    end
    expect_st("freerun", FRE, 0, 0, 1, 0);
    idle(50);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(50);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("fr_to_acq", ACQ, 0, 0, 0, 0);

    // Relock, then an early PPS at ivl 500
    second(1000, 1, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 1, 1);
    expect_st("relock", LCK, 1, 0, 1, 1);
    second(501, 0, 0, 0, 0, 0);
    expect_st("early", ACQ, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 0, 0);
    expect_st("relock_wait", ACQ, 0, 0, 0, 0);
    second(1000, 1, 0, 0, 1, 1);
    expect_st("relock2", LCK, 1, 0, 1, 1);

    // Reset while locked overrides a coincident PPS
    idle(20);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_st("reset_locked", ACQ, 0, 0, 0, 0);
    reset = 1'b0;
    idle(5);

    // Good PPS without time stays in ACQUIRE
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) second(1000, 0, 0, 0, 0, 0);
    expect_st("no_time", ACQ, 0, 0, 0, 0);
    idle(999);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("tv_with_pps", ACQ, 0, 0, 0, 0);
    second(1000, 0, 0, 0, 1, 1);
    expect_st("lock_after_tv", LCK, 1, 0, 1, 1);

    // Window edges while locked: 1010 and 990 good, 989 early
    second(1011, 0, 0, 0, 1, 0);
    expect_st("edge_hi", LCK, 1, 0, 1, 0);
    second(991, 0, 0, 0, 1, 0);
    expect_st("edge_lo", LCK, 1, 0, 1, 0);
    second(990, 0, 0, 0, 0, 0);
    expect_st("edge_early", ACQ, 0, 0, 0, 0);
    idle(5);

    done = 1'b1;
    for (int w = 0; w < 10 && !fin; w++) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
